gb_joypad_ctrl: RTL and testbench
=================================

// Module: gb_joypad_ctrl
// PURPOSE
//   Scans, synchronises and debounces the eight raw Game Boy buttons. Presents them two ways:
//   - to the CPU core, as the P1/JOYP register with select lines and the joypad interrupt;
//   - to the Nios, as an Avalon-MM slave with press edge-capture and a maskable IRQ.
//   Replaces the bare button input port as the single owner of button state.
// PARAMETERS
//   DEBOUNCE_CYCLES  50000  clk cycles between debounce sample ticks (1 ms @ 50 MHz); must be >= 2
//   CNT_W            16     prescaler width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES
// PORTS
//   clk            in   1   system clock
//   reset_n        in   1   asynchronous, active-low reset
//   btn_raw        in   8   raw buttons, 1=pressed: [0]Right [1]Left [2]Up [3]Down [4]A [5]B [6]Select [7]Start
//   p1_wr          in   1   CPU write strobe to P1 (FF00)
//   p1_wdata       in   8   CPU write data; only bits [5:4] used
//   p1_rdata       out  8   P1 read value (combinational)
//   joy_irq        out  1   one-cycle joypad interrupt request pulse to the interrupt controller
//   avs_address    in   2   Avalon word address
//   avs_read       in   1   Avalon read strobe
//   avs_write      in   1   Avalon write strobe
//   avs_writedata  in   32  Avalon write data
//   avs_readdata   out  32  Avalon read data, registered
//   avs_irq        out  1   Nios IRQ: |(edge_cap & irq_mask)
// BEHAVIOUR
//   Reset: all outputs and state go to their reset values asynchronously.
//     - sync flops 0, btn_state 8'h00, hist 0, prescaler 0, sel 2'b11, prev_nib 4'hF
//     - edge_cap 0, irq_mask 0, avs_readdata 0, joy_irq 0, avs_irq 0
//     - reset mid-debounce discards all history
//   Sync: 2-flop synchroniser per bit -> sync[7:0].
//   Prescaler:
//     - counts 0..DEBOUNCE_CYCLES-1 and wraps
//     - tick=1 for one cycle when count==DEBOUNCE_CYCLES-1
//     - first tick occurs DEBOUNCE_CYCLES cycles after reset release
//   Debounce, per bit i, on each tick:
//     - hist[i] <= {hist[i][0], sync[i]}
//     - if hist[i][1:0] and sync[i] are all equal, btn_state[i] <= sync[i]
//     - effect: a level stable for 3 consecutive ticks is accepted; glitches shorter than 2 ticks are rejected
//   P1 select:
//     - p1_wr loads sel <= p1_wdata[5:4]; other bits ignored
//     - sel[0]=0 selects the d-pad (btn_state[3:0]); sel[1]=0 selects buttons (btn_state[7:4])
//   P1 read:
//     - nib = ~((sel[0]?0:btn_state[3:0]) | (sel[1]?0:btn_state[7:4]))
//     - p1_rdata = {2'b11, sel, nib}
//     - with both groups selected the pressed bits are OR-ed; with neither selected nib=4'hF
//   joy_irq:
//     - prev_nib <= nib every cycle
//     - joy_irq <= |(prev_nib & ~nib), i.e. any 1->0 on the nibble, registered
//     - a nibble edge caused by a select write also fires
//   Avalon map (read latency 1: avs_readdata updates the cycle after avs_read, else holds):
//     - addr0 R  : {24'b0, btn_state}
//     - addr1 R/W1C : {24'b0, edge_cap}; edge_cap[i] set on btn_state[i] 0->1
//     - addr2 R/W : irq_mask[7:0], reset 0
//     - addr3 R  : {31'b0, avs_irq}; writes ignored
//     - addr1 write with the same-cycle set of the same bit: the set wins
//     - reads have no side effects
// CONFIGURATION
//   JOYPAD_DEBOUNCE_EN
//     - defined: prescaler plus 3-sample debounce as above
//     - undefined: btn_state <= sync each cycle (total latency 3 clk from btn_raw); prescaler and hist removed
//     - undefined: DEBOUNCE_CYCLES and CNT_W are ignored
//     - undefined: all other behaviour is identical; intended for fast simulation
// TESTING  (DEBOUNCE_CYCLES=4, JOYPAD_DEBOUNCE_EN defined unless stated)
//   - Reset release:
//       -> p1_rdata=8'hFF, avs_readdata=0, joy_irq=0, avs_irq=0
//   - Hold btn_raw=8'h10 (A) stable; write P1=8'h10 (buttons selected):
//       -> btn_state=8'h10 one cycle after the third tick that samples it
//       -> p1_rdata=8'hDE
//       -> joy_irq pulses exactly once
//   - 1-tick glitch on btn_raw[2]:
//       -> btn_state stays 8'h00; no edge_cap, no irq
//   - Press Start with irq_mask=8'h80:
//       -> edge_cap=8'h80, avs_irq=1
//       -> write addr1=32'h80 -> avs_irq=0 next cycle
//       -> W1C in the same cycle as a new set leaves the bit set
//   - Select=2'b00 with Right+A held:
//       -> nib=4'hE
//       -> writing sel 2'b11 -> p1_rdata=8'hFF, no joy_irq
//   - JOYPAD_DEBOUNCE_EN undefined, btn_raw=8'h01:
//       -> avs addr0 read returns 8'h01 on a read issued 3 cycles later

Source files
------------

// File: rtl/gb_joypad_ctrl.sv
// gb_joypad_ctrl: single owner of the eight Game Boy buttons.
//   Synchronises (2 flops) and, when JOYPAD_DEBOUNCE_EN is defined, debounces the raw
//   buttons with a prescaled 3-sample filter. Without JOYPAD_DEBOUNCE_EN the synchronised
//   value is taken directly (3 clk latency) and the debounce parameters are ignored.
//   CPU side : P1/JOYP register (select lines + active-low nibble) and joy_irq pulse.
//   Nios side: Avalon-MM slave, read latency 1, press edge-capture with W1C and IRQ mask.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   btn_raw[7:0]                 raw buttons, 1=pressed (Right,Left,Up,Down,A,B,Select,Start)
//   p1_wr, p1_wdata[7:0]         CPU write to P1; only [5:4] (select) are used
//   p1_rdata[7:0]                P1 read value {2'b11, sel, nib}, combinational
//   joy_irq                      one-cycle pulse on any 1->0 of the P1 nibble
//   avs_address/read/write/writedata/readdata   Avalon-MM slave (4 words)
//   avs_irq                      |(edge_cap & irq_mask)
// Parameters:
//   DEBOUNCE_CYCLES              clk cycles between debounce sample ticks (>= 2)
//   CNT_W                        prescaler width, 2**CNT_W >= DEBOUNCE_CYCLES
module gb_joypad_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  btn_raw,
    input  logic        p1_wr,
    input  logic [7:0]  p1_wdata,
    output logic [7:0]  p1_rdata,
    output logic        joy_irq,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_irq
);

    logic [7:0]  sync1_q, sync2_q;
    logic [7:0]  btn_state_q, btn_state_d;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  nib, prev_nib_q;
    logic        joy_irq_q, joy_irq_d;
    logic [7:0]  edge_cap_q, edge_cap_d;
    logic [7:0]  irq_mask_q, irq_mask_d;
    logic [31:0] avs_readdata_q, avs_readdata_d;
    logic [7:0]  w1c;

    // Only the select bits of P1 and the low byte of Avalon writes carry information.
    logic unused_wdata;
    assign unused_wdata = ^{p1_wdata[7:6], p1_wdata[3:0], avs_writedata[31:8]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef JOYPAD_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       hist0_q, hist0_d;  // most recent tick sample
    logic [7:0]       hist1_q, hist1_d;  // sample from the tick before
    logic             tick;

    assign tick = (cnt_q == CntMax);

    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
        hist0_d     = hist0_q;
        hist1_d     = hist1_q;
        btn_state_d = btn_state_q;
        if (tick) begin
            hist0_d = sync2_q;
            hist1_d = hist0_q;
            // Accept a level only once it has been seen on three consecutive ticks.
            for (int i = 0; i < 8; i++) begin
                if (hist1_q[i] == hist0_q[i] && hist0_q[i] == sync2_q[i]) begin
                    btn_state_d[i] = sync2_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            hist0_q <= 8'h00;
            hist1_q <= 8'h00;
        end else begin
            cnt_q   <= cnt_d;
            hist0_q <= hist0_d;
            hist1_q <= hist1_d;
        end
    end
`else
    // Debounce parameters have no effect in this build.
    logic [31:0] unused_params;
    assign unused_params = DEBOUNCE_CYCLES ^ CNT_W;

    assign btn_state_d = sync2_q;
`endif

    // Active-low nibble; pressed bits of both selected groups are OR-ed together.
    always_comb begin
        logic [3:0] pressed;
        pressed = 4'h0;
        if (!sel_q[0]) pressed = pressed | btn_state_q[3:0];
        if (!sel_q[1]) pressed = pressed | btn_state_q[7:4];
        nib = ~pressed;
    end

    assign p1_rdata = {2'b11, sel_q, nib};

    always_comb begin
        sel_d     = p1_wr ? p1_wdata[5:4] : sel_q;
        joy_irq_d = |(prev_nib_q & ~nib);
    end

    // Newly set bits override a same-cycle write-one-to-clear.
    always_comb begin
        w1c        = (avs_write && avs_address == 2'd1) ? avs_writedata[7:0] : 8'h00;
        edge_cap_d = (edge_cap_q & ~w1c) | (btn_state_d & ~btn_state_q);
        irq_mask_d = (avs_write && avs_address == 2'd2) ? avs_writedata[7:0] : irq_mask_q;
    end

    assign avs_irq = |(edge_cap_q & irq_mask_q);

    always_comb begin
        avs_readdata_d = avs_readdata_q;
        if (avs_read) begin
            unique case (avs_address)
                2'd0:    avs_readdata_d = {24'h0, btn_state_q};
                2'd1:    avs_readdata_d = {24'h0, edge_cap_q};
                2'd2:    avs_readdata_d = {24'h0, irq_mask_q};
                default: avs_readdata_d = {31'h0, avs_irq};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_state_q    <= 8'h00;
            sel_q          <= 2'b11;
            prev_nib_q     <= 4'hF;
            joy_irq_q      <= 1'b0;
            edge_cap_q     <= 8'h00;
            irq_mask_q     <= 8'h00;
            avs_readdata_q <= 32'h0;
        end else begin
            btn_state_q    <= btn_state_d;
            sel_q          <= sel_d;
            prev_nib_q     <= nib;
            joy_irq_q      <= joy_irq_d;
            edge_cap_q     <= edge_cap_d;
            irq_mask_q     <= irq_mask_d;
            avs_readdata_q <= avs_readdata_d;
        end
    end

    assign joy_irq      = joy_irq_q;
    assign avs_readdata = avs_readdata_q;

endmodule

// File: tb/tb_gb_joypad_ctrl.sv
// Scoreboard bench for gb_joypad_ctrl with DEBOUNCE_CYCLES=4. Works with or without
// JOYPAD_DEBOUNCE_EN; the reference model follows whichever build is compiled.
module tb_gb_joypad_ctrl;

    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  btn_raw = 8'h00;
    logic        p1_wr = 1'b0;
    logic [7:0]  p1_wdata = 8'h00;
    logic [7:0]  p1_rdata;
    logic        joy_irq;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'h0;
    logic [31:0] avs_readdata;
    logic        avs_irq;

    always #5 clk = ~clk;

    gb_joypad_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_raw      (btn_raw),
        .p1_wr        (p1_wr),
        .p1_wdata     (p1_wdata),
        .p1_rdata     (p1_rdata),
        .joy_irq      (joy_irq),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata (avs_readdata),
        .avs_irq      (avs_irq)
    );

    // ---------------- reference model ----------------
    logic [7:0]  m_s1, m_s2;     // btn_raw delayed by one and two clocks
    logic [7:0]  m_t0, m_t1;     // last two debounce tick samples (t0 newest)
    logic [7:0]  m_btn, m_edge, m_mask;
    logic [1:0]  m_sel;
    logic [3:0]  m_prev_nib;
    logic        m_joy;
    int unsigned m_cyc;          // clock edges since reset release

    function automatic logic [3:0] f_nib(input logic [7:0] b, input logic [1:0] s);
        logic [3:0] pressed;
        pressed = 4'h0;
        if (!s[0]) pressed = pressed | b[3:0];
        if (!s[1]) pressed = pressed | b[7:4];
        return ~pressed;
    endfunction

    // Button state that the next clock edge will produce.
    function automatic logic [7:0] f_btn_next();
`ifdef JOYPAD_DEBOUNCE_EN
        if ((m_cyc % D) == D - 1)
            return (m_t0 & m_t1 & m_s2) | (m_btn & (m_t0 | m_t1 | m_s2));
        return m_btn;
`else
        return m_s2;
`endif
    endfunction

    function automatic logic [31:0] f_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {24'h0, m_btn};
            2'd1:    return {24'h0, m_edge};
            2'd2:    return {24'h0, m_mask};
            default: return {31'h0, |(m_edge & m_mask)};
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 <= 8'h00; m_s2 <= 8'h00; m_t0 <= 8'h00; m_t1 <= 8'h00;
            m_btn <= 8'h00; m_edge <= 8'h00; m_mask <= 8'h00;
            m_sel <= 2'b11; m_prev_nib <= 4'hF; m_joy <= 1'b0; m_cyc <= 0;
        end else begin
            m_s1  <= btn_raw;
            m_s2  <= m_s1;
            m_cyc <= m_cyc + 1;
            if ((m_cyc % D) == D - 1) begin
                m_t1 <= m_t0;
                m_t0 <= m_s2;
            end
            m_btn  <= f_btn_next();
            m_edge <= (m_edge & ~((avs_write && avs_address == 2'd1) ? avs_writedata[7:0] : 8'h00))
                      | (f_btn_next() & ~m_btn);
            if (avs_write && avs_address == 2'd2) m_mask <= avs_writedata[7:0];
            if (p1_wr) m_sel <= p1_wdata[5:4];
            m_prev_nib <= f_nib(m_btn, m_sel);
            m_joy      <= |(m_prev_nib & ~f_nib(m_btn, m_sel));
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          kind;   // 0 p1_rdata, 1 joy_irq, 2 avs_irq, 3 bench status, 4 avs_readdata
        logic [31:0] exp_v;
        logic [31:0] act_v;
    } dchk_t;

    logic [31:0] exp_q[$];   // expected Avalon read data, in issue order
    dchk_t       dq[$];      // directed checks, evaluated at the next falling edge
    dchk_t       dc;
    logic [31:0] rd_exp;
    logic        rd_valid;
    int          checks = 0;
    int          errors = 0;

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp_v, $time);
        end
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_valid <= 1'b0;
        else          rd_valid <= avs_read;
    end

    always @(negedge clk) begin
        while (dq.size() > 0) begin
            dc = dq.pop_front();
            case (dc.kind)
                0:       cmp("p1_rdata_directed", {24'h0, p1_rdata}, dc.exp_v);
                1:       cmp("joy_irq_directed", {31'h0, joy_irq}, dc.exp_v);
                2:       cmp("avs_irq_directed", {31'h0, avs_irq}, dc.exp_v);
                4:       cmp("avs_readdata_directed", avs_readdata, dc.exp_v);
                default: cmp("bench_status", dc.act_v, dc.exp_v);
            endcase
        end
        if (reset_n) begin
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    cmp("avs_read_unexpected", 32'd1, 32'd0);
                end else begin
                    rd_exp = exp_q.pop_front();
                    cmp("avs_readdata", avs_readdata, rd_exp);
                end
            end
            cmp("p1_rdata", {24'h0, p1_rdata}, {24'h0, 2'b11, m_sel, f_nib(m_btn, m_sel)});
            cmp("joy_irq", {31'h0, joy_irq}, {31'h0, m_joy});
            cmp("avs_irq", {31'h0, avs_irq}, {31'h0, |(m_edge & m_mask)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dir(input int kind, input logic [31:0] exp_v, input logic [31:0] act_v);
        dchk_t c;
        c.kind  = kind;
        c.exp_v = exp_v;
        c.act_v = act_v;
        dq.push_back(c);
    endtask

    task automatic avs_rd(input logic [1:0] a);
        avs_address = a;
        avs_read    = 1'b1;
        exp_q.push_back(f_rd(a));
        step();
        avs_read = 1'b0;
    endtask

    // Read with a fixed expectation from the specification rather than the model.
    task automatic avs_rd_exp(input logic [1:0] a, input logic [31:0] exp_v);
        avs_address = a;
        avs_read    = 1'b1;
        exp_q.push_back(exp_v);
        step();
        avs_read = 1'b0;
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        step();
        avs_write = 1'b0;
    endtask

    task automatic p1_write(input logic [7:0] d);
        p1_wdata = d;
        p1_wr    = 1'b1;
        step();
        p1_wr = 1'b0;
    endtask

    logic [7:0] nxt;
    logic       found;

    initial begin
        // Reset state.
        step();
        step();
        push_dir(0, 32'hFF, 32'h0);
        push_dir(1, 32'h0, 32'h0);
        push_dir(2, 32'h0, 32'h0);
        push_dir(4, 32'h0, 32'h0);
        step();
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) avs_rd_exp(2'(a), 32'h0);

        // A held, buttons group selected.
        p1_write(8'h10);
        btn_raw = 8'h10;
        repeat (20) step();
        avs_rd_exp(2'd0, 32'h10);
        push_dir(0, 32'hDE, 32'h0);
        step();

        // Short glitch on Up: exactly one debounce sample sees it.
        btn_raw = 8'h14;
        repeat (D) step();
        btn_raw = 8'h10;
        repeat (20) step();
`ifdef JOYPAD_DEBOUNCE_EN
        avs_rd_exp(2'd0, 32'h10);
`else
        avs_rd(2'd0);
`endif
        avs_rd(2'd1);

        // Start press with IRQ mask, then W1C.
        avs_wr(2'd1, 32'hFF);
        avs_wr(2'd2, 32'h80);
        btn_raw = 8'h90;
        repeat (20) step();
        push_dir(2, 32'h1, 32'h0);
        avs_rd_exp(2'd1, 32'h80);
        avs_rd_exp(2'd3, 32'h1);
        avs_wr(2'd1, 32'h80);
        push_dir(2, 32'h0, 32'h0);
        step();

        // W1C issued on the very edge where Start is newly accepted: the set wins.
        btn_raw = 8'h10;
        repeat (20) step();
        btn_raw = 8'h90;
        found   = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            nxt = f_btn_next();
            if (nxt[7] && !m_btn[7]) begin
                avs_wr(2'd1, 32'h80);
                found = 1'b1;
            end else begin
                step();
            end
        end
        push_dir(3, 32'h1, {31'h0, found});
        avs_rd_exp(2'd1, 32'h80);
        push_dir(2, 32'h1, 32'h0);
        step();

        // Both groups selected with Right+A, then deselect both.
        btn_raw = 8'h11;
        repeat (20) step();
        p1_write(8'h00);
        push_dir(0, 32'hCE, 32'h0);
        step();
        p1_write(8'h30);
        push_dir(0, 32'hFF, 32'h0);
        push_dir(1, 32'h0, 32'h0);
        step();
        push_dir(1, 32'h0, 32'h0);
        step();

        // Randomised traffic with one mid-run reset.
        for (int it = 0; it < 400; it++) begin
            if (it == 200) begin
                step();
                reset_n = 1'b0;
                step();
                step();
                reset_n = 1'b1;
            end
            case ($urandom_range(0, 4))
                0:       btn_raw = 8'($urandom_range(0, 255));
                1:       p1_write(8'($urandom));
                2:       avs_rd(2'($urandom_range(0, 3)));
                3:       avs_wr(2'($urandom_range(0, 3)), $urandom);
                default: ;
            endcase
            repeat ($urandom_range(0, 6)) step();
        end

        repeat (3) step();
        push_dir(3, 32'h0, 32'(exp_q.size()));
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
